shift_load_sequencer: RTL

- Control stage directly upstream of the 4-bit universal shift register (hold / shift-left with zero fill / parallel load).
- Accepts parallel words over a valid/ready handshake and drives the register's `sel` and `U` inputs: one load cycle, then WIDTH shift-left cycles.
- Samples the register's MSB (T3) on every shift cycle to produce an MSB-first serial stream, with a single-cycle `done` pulse per word.

---
 rtl/shift_ctrl_pkg.sv | 20 ++
 rtl/circuit_ff.sv | 33 +++
 rtl/shift_load_sequencer.sv | 121 ++++++++++++
 3 files changed

// File: rtl/shift_ctrl_pkg.sv
// rtl/shift_ctrl_pkg.sv - shared select codes and state encoding for the shift sequencer
//
// Purpose : mode-select constants for the 4-bit universal shift register and
//           the state encoding of shift_load_sequencer.
// Contents: SEL_HOLD/SEL_SHL/SEL_LOAD, state_t, IDLE/LOAD/SHIFT/PARITY/DONE.
package shift_ctrl_pkg;

  localparam logic [1:0] SEL_HOLD = 2'b00;
  localparam logic [1:0] SEL_SHL  = 2'b01;
  localparam logic [1:0] SEL_LOAD = 2'b10;

  typedef logic [2:0] state_t;

  localparam state_t IDLE   = 3'd0;
  localparam state_t LOAD   = 3'd1;
  localparam state_t SHIFT  = 3'd2;
  localparam state_t PARITY = 3'd3;
  localparam state_t DONE   = 3'd4;

endpackage

// File: rtl/circuit_ff.sv
// rtl/circuit_ff.sv - universal shift register: hold, shift-left zero fill, parallel load
//
// Purpose: WIDTH-bit register driven by shift_load_sequencer.
// Ports  : clk   - clock, rising edge
//          reset - asynchronous active-high reset, clears T
//          sel   - 00 hold, 01 shift left (zero fill), 10 parallel load, 11 hold
//          U     - parallel load data
//          T     - register contents, T[WIDTH-1] is the MSB
module circuit_ff
  import shift_ctrl_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] U,
  output logic [WIDTH-1:0] T
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      T <= '0;
    end else begin
      case (sel)
        SEL_SHL:  T <= {T[WIDTH-2:0], 1'b0};
        SEL_LOAD: T <= U;
        default:  T <= T;
      endcase
    end
  end

endmodule

// File: rtl/shift_load_sequencer.sv
// rtl/shift_load_sequencer.sv - valid/ready word intake driving a shift register into an MSB-first serial stream
//
// Purpose: accepts a WIDTH-bit word, loads it into the downstream shift
//          register, shifts it out MSB first while sampling the register MSB,
//          then pulses done for one cycle.
// Config : define SHIFT_PARITY_EN to append an even-parity bit after the data.
// Ports  : clk       - clock, rising edge
//          reset     - asynchronous active-high reset
//          in_valid  - upstream word available
//          in_ready  - word can be accepted (IDLE only, low during reset)
//          in_data   - word to serialise
//          sel       - shift register mode (00 hold, 01 shift left, 10 load)
//          U         - registered accepted word, to register parallel inputs
//          msb_in    - shift register MSB (T3)
//          ser_out   - serial bit, MSB first
//          ser_valid - ser_out valid this cycle
//          busy      - high outside IDLE
//          done      - one-cycle pulse after the final serial bit
module shift_load_sequencer
  import shift_ctrl_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic [1:0]       sel,
  output logic [WIDTH-1:0] U,
  input  logic             msb_in,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] u_q, u_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    u_d     = u_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          u_d     = in_data;
          cnt_d   = '0;
          state_d = LOAD;
        end
      end
      LOAD: state_d = SHIFT;
      SHIFT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
`ifdef SHIFT_PARITY_EN
          state_d = PARITY;
`else
          state_d = DONE;
`endif
        end
      end
`ifdef SHIFT_PARITY_EN
      PARITY: state_d = DONE;
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      u_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      u_q     <= u_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are decoded from the state alone; reset forces IDLE immediately,
  // and in_ready is additionally gated so it stays low while reset is held.
  always_comb begin
    sel       = SEL_HOLD;
    in_ready  = 1'b0;
    ser_out   = 1'b0;
    ser_valid = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        busy     = 1'b0;
        in_ready = ~reset;
      end
      LOAD: sel = SEL_LOAD;
      SHIFT: begin
        sel       = SEL_SHL;
        ser_valid = 1'b1;
        ser_out   = msb_in;
      end
`ifdef SHIFT_PARITY_EN
      PARITY: begin
        ser_valid = 1'b1;
        ser_out   = ^u_q;
      end
`endif
      DONE:    done = 1'b1;
      default: busy = 1'b1;
    endcase
  end

  assign U = u_q;

endmodule
